// File: rtl/key_conditioner.sv
// Key debouncer with auto-repeat: turns a synchronized key level into one-cycle
// press strobes, a debounced held level and a wrapping count of strobes.
module key_conditioner #(
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned REPEAT_DELAY = 16,
  parameter int unsigned REPEAT_RATE  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  input  logic       repeat_en,
  output logic       pulse,
  output logic       held,
  output logic [7:0] press_count
);

  localparam int unsigned CW = 8;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] DB_PRESS   = 3'd1;
  localparam logic [2:0] HELD       = 3'd2;
  localparam logic [2:0] REPEAT     = 3'd3;
  localparam logic [2:0] DB_RELEASE = 3'd4;

  // Terminal timer values: the transition fires on the edge that sees cnt at these.
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

  logic [2:0]    state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          pulse_next;
  logic          held_next;
  logic [CW-1:0] press_count_next;

  // State, shared timer and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pulse       <= 1'b0;
      held        <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      pulse       <= pulse_next;
      held        <= held_next;
      press_count <= press_count_next;
    end
  end

  // Next-state, timer and output values
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pulse_next = 1'b0;
    held_next  = held;

    case (state)
      IDLE: begin
        cnt_next  = '0;
        held_next = 1'b0;
        if (key) begin
          state_next = DB_PRESS;
          cnt_next   = CW'(1);
        end
      end

      DB_PRESS: begin
        if (!key) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == DB_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          held_next  = 1'b1;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end

      HELD, REPEAT: begin
        if (!key) begin
          state_next = DB_RELEASE;
          cnt_next   = CW'(1);
        end else if (!repeat_en) begin
          cnt_next = '0;
        end else if (cnt == ((state == HELD) ? DELAY_LAST : RATE_LAST)) begin
          state_next = REPEAT;
          cnt_next   = '0;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end

      DB_RELEASE: begin
        if (key) begin
          // Release glitch: back to held, full initial repeat delay again
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt == DB_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          held_next  = 1'b0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        held_next  = 1'b0;
      end
    endcase
  end

  assign press_count_next = press_count + CW'(pulse_next);

endmodule

// File: tb/tb_key_conditioner.sv
// Directed scenarios plus randomized key/repeat_en traffic against a run-length
// reference model of the key conditioner.
module tb_key_conditioner;

  localparam int DEBOUNCE     = 4;
  localparam int REPEAT_DELAY = 16;
  localparam int REPEAT_RATE  = 8;

  logic       clk;
  logic       reset;
  logic       key;
  logic       repeat_en;
  logic       pulse;
  logic       held;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;

  // Reference model: debounced level, length of the current disagreeing run,
  // and cycles since the last repeat reference point.
  bit         m_held;
  int         m_run;
  int         m_since;
  bit         m_first;
  bit         m_pulse;
  logic [7:0] m_count;

  key_conditioner #(
    .DEBOUNCE    (DEBOUNCE),
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key        (key),
    .repeat_en  (repeat_en),
    .pulse      (pulse),
    .held       (held),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_held  = 1'b0;
    m_run   = 0;
    m_since = 0;
    m_first = 1'b0;
    m_pulse = 1'b0;
    m_count = 8'd0;
  endfunction

  function automatic void model_edge(input bit k, input bit en);
    m_pulse = 1'b0;
    if (k != m_held) begin
      m_run++;
      if (m_run == DEBOUNCE) begin
        m_held = k;
        m_run  = 0;
        if (k) begin
          m_pulse = 1'b1;
          m_since = 0;
          m_first = 1'b1;
        end
      end
    end else begin
      if (m_held) begin
        if (m_run > 0) begin
          m_since = 0;
          m_first = 1'b1;
        end else if (!en) begin
          m_since = 0;
        end else begin
          m_since++;
          if (m_since == (m_first ? REPEAT_DELAY : REPEAT_RATE)) begin
            m_pulse = 1'b1;
            m_since = 0;
            m_first = 1'b0;
          end
        end
      end
      m_run = 0;
    end
    if (m_pulse) m_count = m_count + 8'd1;
  endfunction

  // One clock edge with the given inputs, then compare against the model.
  task automatic step(input bit k, input bit en);
    key       = k;
    repeat_en = en;
    @(posedge clk);
    model_edge(k, en);
    #1;
    check("model_pulse", {7'd0, pulse}, {7'd0, m_pulse});
    check("model_held", {7'd0, held}, {7'd0, m_held});
    check("model_count", press_count, m_count);
  endtask

  task automatic do_reset(input bit k);
    key       = k;
    repeat_en = 1'b0;
    reset     = 1'b0;
    model_reset();
    #1;
    check("reset_pulse", {7'd0, pulse}, 8'd0);
    check("reset_held", {7'd0, held}, 8'd0);
    check("reset_count", press_count, 8'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    key       = 1'b0;
    repeat_en = 1'b0;
    model_reset();
    #2;

    // Clean press: pulse only after edge 4
    do_reset(1'b0);
    for (int e = 1; e <= 6; e++) begin
      step(1'b1, 1'b0);
      check("clean_pulse", {7'd0, pulse}, {7'd0, (e == 4)});
      check("clean_held", {7'd0, held}, {7'd0, (e >= 4)});
    end
    check("clean_count", press_count, 8'd1);

    // Bounce: key drops at edge 4, accepted pulse only after edge 8
    do_reset(1'b0);
    for (int e = 1; e <= 8; e++) begin
      step(e != 4, 1'b0);
      check("bounce_pulse", {7'd0, pulse}, {7'd0, (e == 8)});
    end
    check("bounce_count", press_count, 8'd1);

    // Auto-repeat: pulses after edges 4, 20, 28, 36
    do_reset(1'b0);
    for (int e = 1; e <= 40; e++) begin
      step(1'b1, 1'b1);
      check("repeat_pulse", {7'd0, pulse},
            {7'd0, (e == 4 || e == 20 || e == 28 || e == 36)});
    end
    check("repeat_count", press_count, 8'd4);

    // Release glitch: short release, then full delay again, then real release
    do_reset(1'b0);
    for (int e = 1; e <= 27; e++) begin
      step(!(e == 5 || e == 6 || e >= 24), 1'b1);
      check("glitch_pulse", {7'd0, pulse}, {7'd0, (e == 4 || e == 23)});
      check("glitch_held", {7'd0, held}, {7'd0, (e >= 4 && e < 27)});
    end

    // Reset mid-repeat, right after a repeat pulse
    do_reset(1'b0);
    for (int e = 1; e <= 28; e++) step(1'b1, 1'b1);
    check("pre_reset_pulse", {7'd0, pulse}, 8'd1);
    check("pre_reset_count", press_count, 8'd3);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("midrep_pulse", {7'd0, pulse}, 8'd0);
    check("midrep_held", {7'd0, held}, 8'd0);
    check("midrep_count", press_count, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // Key already pressed across reset release: full debounce still needed
    do_reset(1'b1);
    for (int e = 1; e <= 5; e++) begin
      step(1'b1, 1'b0);
      check("postrst_pulse", {7'd0, pulse}, {7'd0, (e == 4)});
    end

    // Wrap: 256 clean press/release cycles
    do_reset(1'b0);
    for (int i = 1; i <= 256; i++) begin
      for (int e = 0; e < 5; e++) step(1'b1, 1'b0);
      for (int e = 0; e < 4; e++) step(1'b0, 1'b0);
      if (i == 255) check("wrap_255", press_count, 8'd255);
      if (i == 256) check("wrap_256", press_count, 8'd0);
    end

    // Randomized key runs and repeat_en toggling
    do_reset(1'b0);
    for (int r = 0; r < 300; r++) begin
      bit k;
      int len;
      k   = 1'($urandom_range(0, 1));
      len = (k && $urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                              : int'($urandom_range(1, 6));
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 15) == 0) repeat_en = ~repeat_en;
        step(k, repeat_en);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE, default 4, giving the number of consecutive identical key samples (2..255) needed to accept a press or a release.
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 16, giving the cycles (2..255) from the initial press pulse to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_RATE, default 8, giving the cycles (2..255) between later auto-repeat pulses.
REQ-004 The block SHALL have port: clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-005 The block SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port: key  input  1  key level, already two-flop synchronized to clk by the upstream stage; 1 = pressed.
REQ-007 The block SHALL have port: repeat_en  input  1  auto-repeat enable, sampled every cycle.
REQ-008 The block SHALL have port: pulse  output  1  registered, one-cycle strobe per accepted press or repeat.
REQ-009 The block SHALL have port: held  output  1  registered debounced key level.
REQ-010 The block SHALL have port: press_count  output  8  registered count of pulses.

Function
REQ-011 The FSM SHALL have five states: IDLE, DB_PRESS, HELD, REPEAT and DB_RELEASE; a single 8-bit timer cnt SHALL be shared by all states.
REQ-012 In IDLE with key=1, the FSM SHALL go to DB_PRESS with cnt=1; with key=0 it SHALL stay in IDLE.
REQ-013 In DB_PRESS with key=0, the FSM SHALL return to IDLE and pulse SHALL NOT assert (bounce rejected).
REQ-014 In DB_PRESS, on the edge that takes the DEBOUNCE-th consecutive key=1 sample, the FSM SHALL go to HELD with cnt=0; on that edge held and pulse SHALL be set to 1.
REQ-015 pulse SHALL be high for exactly one cycle per event and SHALL never be high on two consecutive cycles.
REQ-016 In HELD with key=1 and repeat_en=1, cnt SHALL increment; when cnt reaches REPEAT_DELAY-1, the FSM SHALL go to REPEAT with cnt=0 and pulse SHALL be set.
REQ-017 The first repeat pulse SHALL therefore come exactly REPEAT_DELAY cycles after the initial pulse.
REQ-018 In REPEAT with key=1 and repeat_en=1, a pulse SHALL be issued every REPEAT_RATE cycles.
REQ-019 In HELD or REPEAT with repeat_en=0, cnt SHALL be held at 0 and no repeat pulses SHALL be issued.
REQ-020 When repeat_en returns to 1 in HELD or REPEAT, timing SHALL restart from 0 in the current state.
REQ-021 In HELD or REPEAT with key=0, the FSM SHALL go to DB_RELEASE with cnt=1, and held SHALL stay 1.
REQ-022 In DB_RELEASE with key=1 (release glitch), the FSM SHALL return to HELD with cnt=0, SHALL NOT pulse, and SHALL wait the full REPEAT_DELAY again.
REQ-023 In DB_RELEASE, on the edge that takes the DEBOUNCE-th consecutive key=0 sample, the FSM SHALL go to IDLE and held SHALL be cleared to 0.
REQ-024 Releases SHALL never produce a pulse.
REQ-025 press_count SHALL increment by 1 on each edge that sets pulse, wrapping 255->0 with no flag.
REQ-026 IDLE and DB_PRESS SHALL ignore repeat_en.
REQ-027 Unused state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-028 While reset=0, the FSM SHALL be in IDLE with cnt=0, pulse=0, held=0 and press_count=0, asynchronously and regardless of clk.
REQ-029 Reset SHALL take effect immediately even mid-press or mid-repeat.
REQ-030 After reset deasserts, the first edge SHALL evaluate normally; if key is already 1, a full DEBOUNCE must elapse before any pulse.

Verification
REQ-031 The bench SHALL use the default parameters (4/16/8) and SHALL cover the following directed scenarios.
REQ-032 Scenario, clean press: key=1 for edges 1..6, repeat_en=0 -> pulse=1 only after edge 4, held=1 from edge 4, press_count=1.
REQ-033 Scenario, bounce: key=1 edges 1..3, key=0 edge 4, key=1 edges 5..8 -> no pulse through edge 7; single pulse after edge 8; press_count=1.
REQ-034 Scenario, auto-repeat: key=1 edges 1..40, repeat_en=1 -> pulses after edges 4, 20, 28 and 36 only; press_count=4.
REQ-035 Scenario, release glitch: after HELD, key=0 for 2 edges then key=1 -> held stays 1 and no pulse; next first repeat comes 16 cycles later; key=0 for 4 edges -> held=0 after the 4th edge.
REQ-036 Scenario, reset mid-repeat: reset=0 between edges while in REPEAT -> pulse, held and press_count go to 0 before the next edge.
REQ-037 Scenario, wrap: 256 clean press/release cycles -> press_count reads 255 after the 255th press and 0 after the 256th.
